// File: rtl/alu_module.sv
// rtl/alu_module.sv - register-fed 8-bit ALU with shared input bus and MIPS-style funct opcodes
// Operands and opcode are captured from entrada by level-sensitive strobes; result is combinational.
module alu_module #(
  parameter int W   = 8,
  parameter int OPW = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] entrada,
  input  logic         b1,
  input  logic         b2,
  input  logic         b3,
  output logic [W-1:0] result
);

  localparam logic [OPW-1:0] OP_SRL = OPW'(6'h02);
  localparam logic [OPW-1:0] OP_SRA = OPW'(6'h03);
  localparam logic [OPW-1:0] OP_ADD = OPW'(6'h20);
  localparam logic [OPW-1:0] OP_SUB = OPW'(6'h22);
  localparam logic [OPW-1:0] OP_AND = OPW'(6'h24);
  localparam logic [OPW-1:0] OP_OR  = OPW'(6'h25);
  localparam logic [OPW-1:0] OP_XOR = OPW'(6'h26);
  localparam logic [OPW-1:0] OP_NOR = OPW'(6'h27);

  logic [W-1:0]   reg_a;
  logic [W-1:0]   reg_b;
  logic [OPW-1:0] reg_op;
  logic           shift_overflow;

  // Strobes are independent; simultaneous strobes all load the same bus value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_a  <= '0;
      reg_b  <= '0;
      reg_op <= '0;
    end else begin
      if (b1) reg_a  <= entrada;
      if (b2) reg_b  <= entrada;
      if (b3) reg_op <= entrada[OPW-1:0];
    end
  end

  assign shift_overflow = (reg_b >= W[W-1:0]);

  always_comb begin
    result = '0;
    unique case (reg_op)
      OP_ADD: result = reg_a + reg_b;
      OP_SUB: result = reg_a - reg_b;
      OP_AND: result = reg_a & reg_b;
      OP_OR:  result = reg_a | reg_b;
      OP_XOR: result = reg_a ^ reg_b;
      OP_NOR: result = ~(reg_a | reg_b);
      OP_SRL: result = shift_overflow ? '0 : (reg_a >> reg_b);
      // Oversized arithmetic shifts saturate to the replicated sign bit.
      OP_SRA: result = shift_overflow ? {W{reg_a[W-1]}} : W'($signed(reg_a) >>> reg_b);
      default: result = '0;
    endcase
  end

endmodule

// File: tb/tb_alu_module.sv
// tb/tb_alu_module.sv - directed self-checking bench for alu_module
// Each task drives its scenario and checks result against hand-computed values.
module tb_alu_module;

  logic       clk;
  logic       rst;
  logic [7:0] entrada;
  logic       b1;
  logic       b2;
  logic       b3;
  logic [7:0] result;

  int tests;
  int fails;

  alu_module dut (
    .clk(clk),
    .rst(rst),
    .entrada(entrada),
    .b1(b1),
    .b2(b2),
    .b3(b3),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load(input logic s1, input logic s2, input logic s3, input logic [7:0] val);
    @(negedge clk);
    entrada = val;
    b1 = s1;
    b2 = s2;
    b3 = s3;
    @(negedge clk);
    b1 = 1'b0;
    b2 = 1'b0;
    b3 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    tests++;
    if (result !== 8'h00) begin
      fails++;
      $display("FAIL reset_initial: result=%h expected=%h", result, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (result !== 8'h00) begin
      fails++;
      $display("FAIL reset_idle: result=%h expected=%h", result, 8'h00);
    end
    load(1, 0, 0, 8'h07);
    load(0, 1, 0, 8'h03);
    load(0, 0, 1, 8'h20);
    tests++;
    if (result !== 8'h0A) begin
      fails++;
      $display("FAIL reset_preload: result=%h expected=%h", result, 8'h0A);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (result !== 8'h00) begin
      fails++;
      $display("FAIL reset_async: result=%h expected=%h", result, 8'h00);
    end
    // Load attempted while reset is held must be lost.
    @(negedge clk);
    entrada = 8'h20;
    b3 = 1'b1;
    b1 = 1'b1;
    @(negedge clk);
    b1 = 1'b0;
    b3 = 1'b0;
    rst = 1'b0;
    load(0, 1, 0, 8'h01);
    tests++;
    if (result !== 8'h00) begin
      fails++;
      $display("FAIL reset_mid_load: result=%h expected=%h", result, 8'h00);
    end
  endtask

  task automatic test_ops;
    logic [7:0] ops [8];
    logic [7:0] exp [8];
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};
    exp = '{8'h0A, 8'h04, 8'h03, 8'h07, 8'h04, 8'h00, 8'h00, 8'hF8};
    load(1, 0, 0, 8'h07);
    load(0, 1, 0, 8'h03);
    for (int i = 0; i < 8; i++) begin
      load(0, 0, 1, ops[i]);
      tests++;
      if (result !== exp[i]) begin
        fails++;
        $display("FAIL ops_op%h: result=%h expected=%h", ops[i], result, exp[i]);
      end
    end
  endtask

  task automatic test_shifts;
    logic [7:0] bs  [4];
    logic [7:0] ops [4];
    logic [7:0] exp [4];
    bs  = '{8'h02, 8'h02, 8'h09, 8'h09};
    ops = '{8'h02, 8'h03, 8'h02, 8'h03};
    exp = '{8'h24, 8'hE4, 8'h00, 8'hFF};
    load(1, 0, 0, 8'h90);
    for (int i = 0; i < 4; i++) begin
      load(0, 1, 0, bs[i]);
      load(0, 0, 1, ops[i]);
      tests++;
      if (result !== exp[i]) begin
        fails++;
        $display("FAIL shift_b%h_op%h: result=%h expected=%h", bs[i], ops[i], result, exp[i]);
      end
    end
    load(1, 0, 0, 8'h70);
    load(0, 1, 0, 8'h08);
    tests++;
    if (result !== 8'h00) begin
      fails++;
      $display("FAIL shift_sra_pos_big: result=%h expected=%h", result, 8'h00);
    end
  endtask

  task automatic test_wrap;
    load(1, 0, 0, 8'hFF);
    load(0, 1, 0, 8'h01);
    load(0, 0, 1, 8'h20);
    tests++;
    if (result !== 8'h00) begin
      fails++;
      $display("FAIL wrap_add: result=%h expected=%h", result, 8'h00);
    end
    load(1, 0, 0, 8'h01);
    load(0, 1, 0, 8'h02);
    load(0, 0, 1, 8'h22);
    tests++;
    if (result !== 8'hFF) begin
      fails++;
      $display("FAIL wrap_sub: result=%h expected=%h", result, 8'hFF);
    end
  endtask

  task automatic test_opcode_decode;
    load(1, 0, 0, 8'h09);
    load(0, 1, 0, 8'h04);
    load(0, 0, 1, 8'hE2);
    tests++;
    if (result !== 8'h05) begin
      fails++;
      $display("FAIL op_upper_ignored: result=%h expected=%h", result, 8'h05);
    end
    load(0, 0, 1, 8'h21);
    tests++;
    if (result !== 8'h00) begin
      fails++;
      $display("FAIL op_undefined: result=%h expected=%h", result, 8'h00);
    end
  endtask

  task automatic test_simultaneous;
    load(0, 0, 1, 8'h20);
    load(1, 1, 0, 8'h05);
    tests++;
    if (result !== 8'h0A) begin
      fails++;
      $display("FAIL simultaneous_ab: result=%h expected=%h", result, 8'h0A);
    end
  endtask

  task automatic test_hold;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      entrada = 8'h3C + 8'(i * 17);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (result !== 8'h0A) begin
      fails++;
      $display("FAIL hold_no_strobe: result=%h expected=%h", result, 8'h0A);
    end
  endtask

  task automatic test_back_to_back;
    // Strobe held high over consecutive edges keeps reloading.
    @(negedge clk);
    b1 = 1'b1;
    entrada = 8'h10;
    @(negedge clk);
    entrada = 8'h20;
    @(negedge clk);
    b1 = 1'b0;
    tests++;
    if (result !== 8'h25) begin
      fails++;
      $display("FAIL back_to_back_reload: result=%h expected=%h", result, 8'h25);
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst     = 1'b1;
    entrada = 8'h00;
    b1      = 1'b0;
    b2      = 1'b0;
    b3      = 1'b0;
    test_reset;
    test_ops;
    test_shifts;
    test_wrap;
    test_opcode_decode;
    test_simultaneous;
    test_hold;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
